// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op encodings and defaults shared by the logic execute unit
package logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_RSVD = 2'b11
  } logic_op_e;

  localparam int IMM_SEL_BIT = 2;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_IMM_WIDTH  = 12;
  localparam int DEF_TAG_WIDTH  = 5;
  localparam int DEF_STAGES     = 2;

endpackage

// File: rtl/logic_pipe_stage.sv
// rtl/logic_pipe_stage.sv - one elastic valid/ready register stage with parametrised payload
module logic_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // An empty stage always loads, so bubbles collapse toward the output.
  assign up_ready_o = !valid_q || dn_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (up_ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) data_d = up_data_i;
    end
    if (clear_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

endmodule

// File: rtl/logic_exec_unit.sv
// rtl/logic_exec_unit.sv - pipelined AND/OR/XOR execute unit; LOGIC_UNIT_FLUSH_EN adds a flush port
module logic_exec_unit
  import logic_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMM_WIDTH  = DEF_IMM_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int STAGES     = DEF_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [IMM_WIDTH-1:0]  in_imm,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_illegal
`ifdef LOGIC_UNIT_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int PW = DATA_WIDTH + TAG_WIDTH + 1;

  logic                  kill;
  logic [DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] result;
  logic                  illegal;

  logic            valid_s [STAGES+1];
  logic            ready_s [STAGES+1];
  logic [PW-1:0]   data_s  [STAGES+1];

`ifdef LOGIC_UNIT_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    operand2 = in_op[IMM_SEL_BIT] ? DATA_WIDTH'($signed(in_imm)) : in_src2;
    result   = '0;
    illegal  = 1'b0;
    case (logic_op_e'(in_op[1:0]))
      OP_AND:  result = in_src1 & operand2;
      OP_OR:   result = in_src1 | operand2;
      OP_XOR:  result = in_src1 ^ operand2;
      default: illegal = 1'b1;
    endcase
  end

  // Flush keeps stage 1 from loading and clears every stage in the same edge.
  assign valid_s[0] = in_valid && !kill;
  assign data_s[0]  = {illegal, in_tag, result};
  assign in_ready   = ready_s[0] && !kill;

  assign ready_s[STAGES] = out_ready;

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    logic_pipe_stage #(.WIDTH(PW)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (kill),
      .up_valid_i (valid_s[g-1]),
      .up_ready_o (ready_s[g-1]),
      .up_data_i  (data_s[g-1]),
      .dn_valid_o (valid_s[g]),
      .dn_ready_i (ready_s[g]),
      .dn_data_o  (data_s[g])
    );
  end

  assign out_valid   = valid_s[STAGES];
  assign out_result  = out_valid ? data_s[STAGES][DATA_WIDTH-1:0] : '0;
  assign out_tag     = out_valid ? data_s[STAGES][DATA_WIDTH +: TAG_WIDTH] : '0;
  assign out_illegal = out_valid && data_s[STAGES][PW-1];

endmodule

// File: tb/tb_logic_exec_unit.sv
// tb/tb_logic_exec_unit.sv - randomized scoreboard bench for logic_exec_unit
module tb_logic_exec_unit;

  localparam int DW = 32;
  localparam int IW = 12;
  localparam int TW = 5;
  localparam int ST = 2;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [DW-1:0] in_src1;
  logic [DW-1:0] in_src2;
  logic [IW-1:0] in_imm;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          out_illegal;
  logic          flush;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  logic_exec_unit #(.DATA_WIDTH(DW), .IMM_WIDTH(IW), .TAG_WIDTH(TW), .STAGES(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .in_imm      (in_imm),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
`ifdef LOGIC_UNIT_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  function automatic logic [DW-1:0] ref_result(input logic [2:0] op, input logic [DW-1:0] s1,
                                               input logic [DW-1:0] s2, input logic [IW-1:0] imm);
    longint unsigned b, a, r, ext;
    a = longint'(s1);
    ext = longint'(imm);
    if (ext >= (64'd1 << (IW - 1))) ext = ext + (64'd1 << DW) - (64'd1 << IW);
    b = op[2] ? ext : longint'(s2);
    case (op[1:0])
      2'd0: r = a & b;
      2'd1: r = a | b;
      2'd2: r = a ^ b;
      default: r = 0;
    endcase
    return DW'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                          input logic [IW-1:0] imm, input logic [TW-1:0] tag);
    in_op = op; in_src1 = s1; in_src2 = s2; in_imm = imm; in_tag = tag;
  endtask

  task automatic rand_op(output exp_t e);
    logic [2:0]    op;
    logic [DW-1:0] s1, s2;
    logic [IW-1:0] imm;
    logic [TW-1:0] tag;
    op = 3'($urandom_range(0, 7));
    s1 = $urandom; s2 = $urandom; imm = IW'($urandom); tag = TW'($urandom);
    drive_op(op, s1, s2, imm, tag);
    e.res = ref_result(op, s1, s2, imm);
    e.tag = tag;
    e.ill = (op[1:0] == 2'b11);
  endtask

  task automatic issue_wait(input logic [2:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                            input logic [IW-1:0] imm, input logic [TW-1:0] tag, output int lat,
                            output logic [DW-1:0] r, output logic [TW-1:0] t, output logic il);
    drive_op(op, s1, s2, imm, tag);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    r = out_result; t = out_tag; il = out_illegal;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive_op(3'b000, '0, '0, '0, '0);
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL reset_out_illegal got=%b want=0", out_illegal); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    tick();
  endtask

  task automatic test_directed();
    int lat;
    logic [DW-1:0] r;
    logic [TW-1:0] t;
    logic il;
    issue_wait(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 5'd3, lat, r, t, il);
    total++; if (lat != ST - 1) begin bad++; $display("FAIL and_latency got=%0d want=%0d", lat, ST - 1); end
    total++; if (r !== 32'hF000_F000) begin bad++; $display("FAIL and_result got=%h want=f000f000", r); end
    total++; if (t !== 5'd3) begin bad++; $display("FAIL and_tag got=%0d want=3", t); end
    total++; if (il !== 1'b0) begin bad++; $display("FAIL and_illegal got=%b want=0", il); end
    issue_wait(3'b101, 32'h0000_0010, 32'h1234_5678, 12'h800, 5'd7, lat, r, t, il);
    total++; if (r !== 32'hFFFF_F810) begin bad++; $display("FAIL ori_sext got=%h want=fffff810", r); end
    issue_wait(3'b110, 32'hFFFF_FFFF, 32'h0, 12'h7FF, 5'd9, lat, r, t, il);
    total++; if (r !== 32'hFFFF_F800) begin bad++; $display("FAIL xori_result got=%h want=fffff800", r); end
    issue_wait(3'b011, 32'hDEAD_BEEF, 32'hCAFE_F00D, 12'h123, 5'd30, lat, r, t, il);
    total++; if (r !== '0) begin bad++; $display("FAIL rsvd_result got=%h want=0", r); end
    total++; if (il !== 1'b1) begin bad++; $display("FAIL rsvd_illegal got=%b want=1", il); end
    total++; if (t !== 5'd30) begin bad++; $display("FAIL rsvd_tag got=%0d want=30", t); end
  endtask

  task automatic test_back_to_back();
    exp_t e, f;
    int sent = 0, got = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (sent < 8) begin rand_op(e); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (in_valid) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_spurious cyc=%0d got=out_valid want=empty", cyc);
        end else begin
          f = q.pop_front();
          total++;
          if (out_result !== f.res || out_tag !== f.tag || out_illegal !== f.ill) begin
            bad++; $display("FAIL b2b_data got=%h/%0d/%b want=%h/%0d/%b", out_result, out_tag, out_illegal, f.res, f.tag, f.ill);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(e); sent++; end
      tick();
    end
    in_valid = 1'b0;
    total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
    total++; if (last - first != 7) begin bad++; $display("FAIL b2b_consecutive got=%0d want=7", last - first); end
    total++; if (first != ST) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", first, ST); end
    q.delete();
  endtask

  task automatic test_backpressure();
    exp_t e, f;
    int acc = 0;
    bit pending = 0, have_hold = 0;
    logic [DW-1:0] hold_r;
    logic [TW-1:0] hold_t;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (!pending) begin rand_op(e); pending = 1; end
      in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== (q.size() < ST)) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, q.size() < ST);
      end
      if (out_valid) begin
        if (have_hold) begin
          total++;
          if (out_result !== hold_r || out_tag !== hold_t) begin
            bad++; $display("FAIL bp_stable got=%h/%0d want=%h/%0d", out_result, out_tag, hold_r, hold_t);
          end
        end
        hold_r = out_result; hold_t = out_tag; have_hold = 1;
      end
      if (in_ready) begin q.push_back(e); pending = 0; acc++; end
      tick();
    end
    total++; if (acc != ST) begin bad++; $display("FAIL bp_accepts got=%0d want=%0d", acc, ST); end
    total++; if (!have_hold) begin bad++; $display("FAIL bp_out_valid got=0 want=1"); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && (q.size() > 0 || pending); cyc++) begin
      in_valid = pending;
      #1;
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_spurious got=out_valid want=empty");
        end else begin
          f = q.pop_front();
          if (out_result !== f.res || out_tag !== f.tag) begin
            bad++; $display("FAIL bp_drain got=%h/%0d want=%h/%0d", out_result, out_tag, f.res, f.tag);
          end
        end
      end
      if (in_valid && in_ready) begin q.push_back(e); pending = 0; end
      tick();
    end
    in_valid = 1'b0;
    total++; if (q.size() != 0 || pending) begin bad++; $display("FAIL bp_lost got=%0d want=0", q.size()); end
    q.delete();
  endtask

  task automatic test_random();
    exp_t e, f;
    bit pending = 0, stalled = 0;
    logic [DW-1:0] prev_r;
    logic [TW-1:0] prev_t;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pending && $urandom_range(0, 9) < 7) begin rand_op(e); pending = 1; end
      in_valid = pending;
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      total++;
      if (in_ready !== ((q.size() < ST) || out_ready)) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, (q.size() < ST) || out_ready);
      end
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_result !== prev_r || out_tag !== prev_t) begin
          bad++; $display("FAIL rnd_stable cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_result, prev_r);
        end
      end
      stalled = 0;
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious cyc=%0d got=out_valid want=empty", cyc);
        end else if (out_result !== q[0].res || out_tag !== q[0].tag || out_illegal !== q[0].ill) begin
          bad++; $display("FAIL rnd_data cyc=%0d got=%h/%0d/%b want=%h/%0d/%b", cyc, out_result, out_tag,
                          out_illegal, q[0].res, q[0].tag, q[0].ill);
        end
        if (out_ready && q.size() > 0) f = q.pop_front();
        if (!out_ready) begin stalled = 1; prev_r = out_result; prev_t = out_tag; end
      end
      if (in_valid && in_ready) begin q.push_back(e); pending = 0; end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
      #1;
      if (out_valid) begin
        f = q.pop_front();
        total++;
        if (out_result !== f.res || out_tag !== f.tag) begin
          bad++; $display("FAIL rnd_drain got=%h/%0d want=%h/%0d", out_result, out_tag, f.res, f.tag);
        end
      end
      tick();
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_lost got=%0d want=0", q.size()); end
    q.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    out_ready = 1'b0;
    for (int i = 0; i < ST + 1; i++) begin rand_op(e); in_valid = 1'b1; tick(); end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL rstmid_out_result got=%h want=0", out_result); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    tick();
  endtask

`ifdef LOGIC_UNIT_FLUSH_EN
  task automatic test_flush();
    exp_t e;
    int lat;
    logic [DW-1:0] r;
    logic [TW-1:0] t;
    logic il;
    out_ready = 1'b0;
    for (int i = 0; i < ST; i++) begin rand_op(e); in_valid = 1'b1; tick(); end
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    tick();
    issue_wait(3'b001, 32'h0000_00A0, 32'h0000_000B, 12'h0, 5'd17, lat, r, t, il);
    total++; if (r !== 32'h0000_00AB || t !== 5'd17) begin bad++; $display("FAIL flush_next got=%h/%0d want=000000ab/17", r, t); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef LOGIC_UNIT_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
